// File: rtl/udp_tx_arbiter_if.sv
// AXI4-Stream bundle shared by the two packet sources and the MAC TX path.
interface udp_tx_arbiter_if #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_AXIS_TKEEP_WIDTH = 8
);
  logic                          tvalid;
  logic                          tready;
  logic [C_AXIS_TDATA_WIDTH-1:0] tdata;
  logic [C_AXIS_TKEEP_WIDTH-1:0] tkeep;
  logic                          tuser;
  logic                          tlast;

  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/udp_tx_arbiter.sv
// Whole-packet round-robin arbiter between two AXI4-Stream sources feeding the 10G MAC TX,
// with a forced inter-packet gap and truncation of packets that run past C_MAX_BEATS.
module udp_tx_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_AXIS_TKEEP_WIDTH = 8,
  parameter int C_IFG_CYCLES       = 2,
  parameter int C_MAX_BEATS        = 192
) (
  input  logic                    m00_axis_aclk,
  input  logic                    m00_axis_aresetn,
  udp_tx_arbiter_if.slave         s00_axis,
  udp_tx_arbiter_if.slave         s01_axis,
  udp_tx_arbiter_if.master        m00_axis,
  input  logic [1:0]              src_enable,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic [31:0]             pkt_count0,
  output logic [31:0]             pkt_count1,
  output logic [15:0]             abort_count
);

  localparam int BEAT_W = $clog2(C_MAX_BEATS) + 1;
  localparam int GAP_W  = $clog2(C_IFG_CYCLES + 1) + 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(C_MAX_BEATS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((C_IFG_CYCLES > 0) ? C_IFG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_t;
  localparam state_t POST_PKT = (C_IFG_CYCLES == 0) ? IDLE : GAP;

  state_t                  state, state_nxt;
  logic                    sel, sel_nxt;
  logic                    last_grant, last_grant_nxt;
  logic [BEAT_W-1:0]       beat_cnt, beat_cnt_nxt;
  logic [GAP_W-1:0]        gap_cnt, gap_cnt_nxt;
  logic                    cnt0_inc, cnt1_inc, abort_inc;

  logic [1:0]                    req;
  logic                          src_tvalid, src_tuser, src_tlast;
  logic [C_AXIS_TDATA_WIDTH-1:0] src_tdata;
  logic [C_AXIS_TKEEP_WIDTH-1:0] src_tkeep;
  logic                          force_last;
  logic                          send_hs;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign req        = {s01_axis.tvalid & src_enable[1], s00_axis.tvalid & src_enable[0]};
  assign src_tvalid = sel ? s01_axis.tvalid : s00_axis.tvalid;
  assign src_tdata  = sel ? s01_axis.tdata  : s00_axis.tdata;
  assign src_tkeep  = sel ? s01_axis.tkeep  : s00_axis.tkeep;
  assign src_tuser  = sel ? s01_axis.tuser  : s00_axis.tuser;
  assign src_tlast  = sel ? s01_axis.tlast  : s00_axis.tlast;

  // The last permitted beat of a packet without tlast is marked errored and closed here.
  assign force_last = (beat_cnt == BEAT_LAST) && !src_tlast;
  assign send_hs    = (state == SEND) && src_tvalid && m00_axis.tready;

  assign grant = ((state == SEND) || (state == DRAIN)) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign busy  = (state != IDLE);

  always_comb begin
    state_nxt       = state;
    sel_nxt         = sel;
    last_grant_nxt  = last_grant;
    beat_cnt_nxt    = beat_cnt;
    gap_cnt_nxt     = gap_cnt;
    cnt0_inc        = 1'b0;
    cnt1_inc        = 1'b0;
    abort_inc       = 1'b0;
    m00_axis.tvalid = 1'b0;
    m00_axis.tdata  = src_tdata;
    m00_axis.tkeep  = src_tkeep;
    m00_axis.tuser  = src_tuser;
    m00_axis.tlast  = src_tlast;
    s00_axis.tready = 1'b0;
    s01_axis.tready = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          // The source that did not own the previous packet wins a tie.
          sel_nxt      = last_grant ? !req[0] : req[1];
          beat_cnt_nxt = '0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        m00_axis.tvalid = src_tvalid;
        m00_axis.tuser  = src_tuser | force_last;
        m00_axis.tlast  = src_tlast | force_last;
        s00_axis.tready = !sel && m00_axis.tready;
        s01_axis.tready = sel && m00_axis.tready;
        if (send_hs) begin
          beat_cnt_nxt = beat_cnt + BEAT_W'(1);
          if (src_tlast) begin
            cnt0_inc       = !sel;
            cnt1_inc       = sel;
            last_grant_nxt = sel;
            gap_cnt_nxt    = '0;
            state_nxt      = POST_PKT;
          end else if (beat_cnt == BEAT_LAST) begin
            abort_inc      = 1'b1;
            last_grant_nxt = sel;
            state_nxt      = DRAIN;
          end
        end
      end
      DRAIN: begin
        s00_axis.tready = !sel;
        s01_axis.tready = sel;
        if (src_tvalid && src_tlast) begin
          gap_cnt_nxt = '0;
          state_nxt   = POST_PKT;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_cnt_nxt = gap_cnt + GAP_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state       <= IDLE;
      sel         <= 1'b0;
      last_grant  <= 1'b1;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      pkt_count0  <= '0;
      pkt_count1  <= '0;
      abort_count <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      if (cnt0_inc)  pkt_count0  <= pkt_count0 + 32'd1;
      if (cnt1_inc)  pkt_count1  <= pkt_count1 + 32'd1;
      if (abort_inc) abort_count <= sat_inc16(abort_count);
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: packet-level scoreboard plus literal spot checks.
module tb_udp_tx_arbiter;

  localparam int MAX_B = 8;
  localparam int IFG   = 2;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        user;
    logic        last;
    logic        src;
    int          bub;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  src_enable;
  logic [1:0]  grant;
  logic        busy;
  logic [31:0] pkt_count0, pkt_count1;
  logic [15:0] abort_count;
  logic        bp;

  udp_tx_arbiter_if #(.C_AXIS_TDATA_WIDTH(64), .C_AXIS_TKEEP_WIDTH(8)) s00 ();
  udp_tx_arbiter_if #(.C_AXIS_TDATA_WIDTH(64), .C_AXIS_TKEEP_WIDTH(8)) s01 ();
  udp_tx_arbiter_if #(.C_AXIS_TDATA_WIDTH(64), .C_AXIS_TKEEP_WIDTH(8)) m00 ();

  udp_tx_arbiter #(
    .C_AXIS_TDATA_WIDTH(64),
    .C_AXIS_TKEEP_WIDTH(8),
    .C_IFG_CYCLES(IFG),
    .C_MAX_BEATS(MAX_B)
  ) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(rst_n),
    .s00_axis        (s00),
    .s01_axis        (s01),
    .m00_axis        (m00),
    .src_enable      (src_enable),
    .grant           (grant),
    .busy            (busy),
    .pkt_count0      (pkt_count0),
    .pkt_count1      (pkt_count1),
    .abort_count     (abort_count)
  );

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    hs_total = 0;
  int    exp_cnt0 = 0, exp_cnt1 = 0, exp_abort = 0;
  beat_t q0[$], q1[$], exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Packet model: source stream plus what the MAC must see and which counter it bumps.
  task automatic send_pkt(input int src, input int len, input int id, input int bub_at);
    beat_t b, e;
    for (int i = 0; i < len; i++) begin
      b.data = {8'(src), 8'(id), 16'h0000, 32'(i)};
      b.keep = (i == len - 1) ? 8'h0F : 8'hFF;
      b.user = 1'b0;
      b.last = (i == len - 1);
      b.src  = src[0];
      b.bub  = (i == bub_at && i > 0) ? 1 : 0;
      if (src == 1) q1.push_back(b);
      else          q0.push_back(b);
      if (i < MAX_B) begin
        e = b;
        if (len > MAX_B && i == MAX_B - 1) begin
          e.last = 1'b1;
          e.user = 1'b1;
        end
        exp_q.push_back(e);
      end
    end
    if (len > MAX_B)    exp_abort++;
    else if (src == 1)  exp_cnt1++;
    else                exp_cnt0++;
  endtask

  task automatic check_counts(input string nm);
    chk({nm, "_pkt_count0"}, pkt_count0, exp_cnt0);
    chk({nm, "_pkt_count1"}, pkt_count1, exp_cnt1);
    chk({nm, "_abort_count"}, abort_count, exp_abort);
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
          !busy && !s00.tvalid && !s01.tvalid) break;
    end
    chk({nm, "_reached_idle"}, (i < 3000), 1);
  endtask

  // Source drivers: present the queue head, pop on handshake, honour bubbles.
  initial begin : drv0
    logic hs;
    int   w;
    w = 0;
    s00.tvalid = 1'b0; s00.tdata = '0; s00.tkeep = '0; s00.tuser = 1'b0; s00.tlast = 1'b0;
    forever begin
      @(negedge clk);
      hs = s00.tvalid && s00.tready;
      @(posedge clk); #1;
      if (hs) begin
        void'(q0.pop_front());
        w = (q0.size() > 0) ? q0[0].bub : 0;
      end
      if (w > 0) begin
        s00.tvalid = 1'b0;
        w--;
      end else if (q0.size() > 0) begin
        s00.tvalid = 1'b1;
        s00.tdata  = q0[0].data;
        s00.tkeep  = q0[0].keep;
        s00.tuser  = q0[0].user;
        s00.tlast  = q0[0].last;
      end else begin
        s00.tvalid = 1'b0;
      end
    end
  end

  initial begin : drv1
    logic hs;
    int   w;
    w = 0;
    s01.tvalid = 1'b0; s01.tdata = '0; s01.tkeep = '0; s01.tuser = 1'b0; s01.tlast = 1'b0;
    forever begin
      @(negedge clk);
      hs = s01.tvalid && s01.tready;
      @(posedge clk); #1;
      if (hs) begin
        void'(q1.pop_front());
        w = (q1.size() > 0) ? q1[0].bub : 0;
      end
      if (w > 0) begin
        s01.tvalid = 1'b0;
        w--;
      end else if (q1.size() > 0) begin
        s01.tvalid = 1'b1;
        s01.tdata  = q1[0].data;
        s01.tkeep  = q1[0].keep;
        s01.tuser  = q1[0].user;
        s01.tlast  = q1[0].last;
      end else begin
        s01.tvalid = 1'b0;
      end
    end
  end

  initial begin : sink
    m00.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m00.tready = bp ? !m00.tready : 1'b1;
    end
  end

  // Per-cycle compare against the scoreboard.
  initial begin : compare
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m00.tvalid && m00.tready) begin
          hs_total++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_m00_beat: actual data=%h required no beat", m00.tdata);
          end else begin
            e = exp_q.pop_front();
            chk("m00_tdata", m00.tdata, e.data);
            chk("m00_tkeep", m00.tkeep, e.keep);
            chk("m00_tuser", m00.tuser, e.user);
            chk("m00_tlast", m00.tlast, e.last);
            chk("grant_owner", grant, {e.src, !e.src});
          end
        end
        chk("tready_exclusive", s00.tready & s01.tready, 0);
        if (m00.tvalid) chk("busy_with_valid", busy, 1);
        if (m00.tvalid && grant == 2'b01) chk("s00_tready_mirror", s00.tready, m00.tready);
        if (m00.tvalid && grant == 2'b10) chk("s01_tready_mirror", s01.tready, m00.tready);
      end
    end
  end

  initial begin : stim
    int c0, c1, i, base, seen;
    logic [63:0] ab_data;
    logic        ab_last;

    rst_n = 1'b0;
    src_enable = 2'b11;
    bp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m00_tvalid", m00.tvalid, 0);
    chk("rst_s00_tready", s00.tready, 0);
    chk("rst_s01_tready", s01.tready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    check_counts("rst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 6-beat packet from source 0.
    send_pkt(0, 6, 0, -1);
    for (i = 0; i < 50; i++) begin @(negedge clk); #1; if (s00.tvalid) break; end
    c0 = cyc;
    for (i = 0; i < 50; i++) begin @(negedge clk); #1; if (m00.tvalid) break; end
    c1 = cyc;
    chk("arb_latency", c1 - c0, 1);
    chk("first_beat_data", m00.tdata, 64'h0);
    for (i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (m00.tvalid && m00.tready && m00.tlast) break;
    end
    chk("t1_tlast_seen", (i < 50), 1);
    @(negedge clk); #1;
    chk("gap1_busy", busy, 1);
    chk("gap1_grant", grant, 0);
    chk("gap1_m00_tvalid", m00.tvalid, 0);
    chk("t1_pkt_count0_lit", pkt_count0, 32'd1);
    @(negedge clk); #1;
    chk("gap2_busy", busy, 1);
    @(negedge clk); #1;
    chk("post_gap_busy", busy, 0);
    wait_idle("t1");
    check_counts("t1");

    // Reset during beat 3 of a packet.
    send_pkt(0, 6, 1, -1);
    base = hs_total;
    for (i = 0; i < 100; i++) begin @(negedge clk); #1; if (hs_total == base + 3) break; end
    chk("t6_three_beats", hs_total - base, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q0.delete();
    exp_q.delete();
    exp_cnt0 = 0; exp_cnt1 = 0; exp_abort = 0;
    #1;
    chk("midrst_m00_tvalid", m00.tvalid, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pkt_count0_lit", pkt_count0, 32'd0);
    check_counts("midrst");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_idle("t6");

    // Both sources continuously offering 4-beat packets: strict alternation from source 0.
    for (int p = 0; p < 4; p++) begin
      send_pkt(0, 4, 16 + p, -1);
      send_pkt(1, 4, 16 + p, -1);
    end
    wait_idle("t2");
    chk("t2_pkt_count0_lit", pkt_count0, 32'd4);
    chk("t2_pkt_count1_lit", pkt_count1, 32'd4);
    check_counts("t2");

    // Backpressure toggling plus a source bubble mid-packet.
    bp = 1'b1;
    send_pkt(0, 6, 32, 3);
    wait_idle("t3");
    bp = 1'b0;
    chk("t3_pkt_count0_lit", pkt_count0, 32'd5);
    check_counts("t3");

    // Runaway packet: 12 beats against an 8-beat limit.
    send_pkt(1, 12, 3, -1);
    ab_data = '0;
    ab_last = 1'b0;
    for (i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (m00.tvalid && m00.tready && m00.tuser) begin
        ab_data = m00.tdata;
        ab_last = m00.tlast;
        break;
      end
    end
    chk("abort_beat_data_lit", ab_data, 64'h0103_0000_0000_0007);
    chk("abort_beat_tlast_lit", ab_last, 1);
    wait_idle("t4");
    chk("t4_abort_count_lit", abort_count, 16'd1);
    chk("t4_pkt_count1_lit", pkt_count1, 32'd4);
    check_counts("t4");

    // Exactly the maximum length with tlast on its final beat is legal.
    send_pkt(0, MAX_B, 4, -1);
    wait_idle("t4b");
    chk("t4b_pkt_count0_lit", pkt_count0, 32'd6);
    chk("t4b_abort_count_lit", abort_count, 16'd1);
    check_counts("t4b");

    // Source 0 masked; enabling it mid-packet waits for the packet and its gap.
    src_enable = 2'b10;
    send_pkt(1, 4, 5, -1);
    send_pkt(0, 4, 6, -1);
    seen = 0;
    for (i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      chk("t5_s00_tready_masked", s00.tready, 0);
      if (m00.tvalid && m00.tready) begin
        chk("t5_grant_s1", grant, 2'b10);
        seen++;
        if (seen == 2) src_enable = 2'b11;
        if (m00.tlast) break;
      end
    end
    chk("t5_s1_beats", seen, 4);
    for (int g = 0; g < IFG; g++) begin
      @(negedge clk); #1;
      chk("t5_gap_s00_tready", s00.tready, 0);
      chk("t5_gap_grant", grant, 0);
    end
    wait_idle("t5");
    chk("t5_pkt_count0_lit", pkt_count0, 32'd7);
    chk("t5_pkt_count1_lit", pkt_count1, 32'd5);
    check_counts("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single 64-bit AXI4-Stream TX path into the 10G MAC between two packet sources, e.g. the UDP packet generator and a second stream source.
- Arbitrates whole packets round-robin, so words from different packets never interleave.
- Enforces a minimum idle gap between packets and aborts runaway packets that never assert tlast.
- Exposes per-source packet counters and an abort counter for AXI-Lite readback by the parent.

Parameters:
- C_AXIS_TDATA_WIDTH, 64, data width of all streams.
- C_AXIS_TKEEP_WIDTH, 8, keep width (C_AXIS_TDATA_WIDTH/8).
- C_IFG_CYCLES, 2, idle cycles forced after each packet (0 allowed).
- C_MAX_BEATS, 192, maximum beats per packet before abort (≥2).

Ports:
- m00_axis_aclk  in  1  single clock for every interface.
- m00_axis_aresetn  in  1  asynchronous active-low reset.
- s00_axis_tvalid/tready/tdata/tkeep/tuser/tlast  in/out/in/in/in/in  1/1/64/8/1/1  source 0 stream.
- s01_axis_tvalid/tready/tdata/tkeep/tuser/tlast  in/out/in/in/in/in  1/1/64/8/1/1  source 1 stream.
- m00_axis_tvalid/tready/tdata/tkeep/tuser/tlast  out/in/out/out/out/out  1/1/64/8/1/1  to MAC TX.
- src_enable  in  2  per-source arbitration enable; bit0 = source 0.
- grant  out  2  one-hot current owner; 0 when not in SEND or DRAIN.
- busy  out  1  high in SEND, DRAIN or GAP.
- pkt_count0  out  32  packets completed from source 0.
- pkt_count1  out  32  packets completed from source 1.
- abort_count  out  16  packets aborted for exceeding C_MAX_BEATS.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
  - Clock port is m00_axis_aclk; reset port is m00_axis_aresetn.
- Reset values:
  - state = IDLE, last_grant = source 1 (so source 0 wins the first tie), beat_cnt = 0, gap_cnt = 0.
  - All counters = 0; grant = 0; busy = 0.
  - m00_axis_tvalid = 0; s00_axis_tready = s01_axis_tready = 0.
  - Reset asserted mid-packet clears everything immediately. The partial packet is not completed and is not counted.
- State machine IDLE / SEND / DRAIN / GAP, with the registered grant index sel:
  - IDLE
    - Request vector req = {s01_tvalid & en[1], s00_tvalid & en[0]}.
    - If req is nonzero, pick round-robin: the source other than last_grant wins if it requests, otherwise the requesting one.
    - Register sel, clear beat_cnt, go to SEND.
    - All treadys and m00_axis_tvalid are 0 in IDLE. This gives one cycle of arbitration latency.
  - SEND
    - Combinational pass-through of the selected source's valid/tdata/tkeep/tuser/tlast to m00; m00_axis_tready goes to the selected tready.
    - The unselected tready is 0.
    - beat_cnt increments on each m00 handshake.
    - Handshake with tlast=1: increment pkt_count[sel], set last_grant = sel, go to GAP (or directly to IDLE if C_IFG_CYCLES = 0).
    - Handshake where beat_cnt == C_MAX_BEATS-1 and the source tlast = 0:
      - Force m00_axis_tlast = 1 and m00_axis_tuser = 1 on that beat (data passes through unchanged).
      - Increment abort_count (saturating at 16'hFFFF), set last_grant = sel, go to DRAIN.
  - DRAIN
    - m00_axis_tvalid = 0; selected tready = 1; discard source beats.
    - On a source beat with tvalid & tlast, go to GAP. The packet is not counted in pkt_count.
  - GAP
    - tvalid and treadys are 0.
    - gap_cnt counts C_IFG_CYCLES cycles, then the block goes to IDLE.
- src_enable is sampled only in IDLE. Deasserting it mid-packet does not cut the packet.
- A source may drop tvalid mid-packet. The arbiter holds the grant, and bubbles pass through unchanged.
- m00_axis_tready low stalls the source with no data loss. Data and tlast stay stable because the path is pure combinational.
- pkt_count0 and pkt_count1 wrap modulo 2^32.
- A packet of exactly C_MAX_BEATS beats, with tlast on its final beat, is legal and is not aborted.

Test Plan:
- Source 0 only, 6-beat packet, tdata 0..5, m00_axis_tready = 1:
  - m00 shows 6 beats starting 1 cycle after s00 tvalid, tlast on beat 5.
  - pkt_count0 = 1; then 2 cycles of GAP; busy high throughout.
- Both sources continuously offer 4-beat packets:
  - Output order is s0, s1, s0, s1 with no interleaving.
  - After 8 packets, pkt_count0 = pkt_count1 = 4.
- Backpressure: m00_axis_tready toggles 1,0,1,0 during a 6-beat packet:
  - All 6 words arrive in order with no duplicates.
  - s00_axis_tready mirrors m00_axis_tready.
- Runaway packet with C_MAX_BEATS = 8: source 1 sends 12 beats with tlast on beat 11:
  - m00 gets 8 beats, beat 7 has tlast = 1 and tuser = 1.
  - Beats 8–11 are consumed with m00_axis_tvalid = 0; abort_count = 1; pkt_count1 = 0.
- src_enable = 2'b10 while both sources request:
  - Only source 1 is granted; s00_axis_tready stays 0.
  - Setting src_enable = 2'b11 mid-packet grants source 0 only after that packet and its gap.
- Reset pulse during beat 3 of a packet:
  - m00_axis_tvalid, grant, busy and all counters read 0 in the same cycle.
  - After release, the next packet starts cleanly from IDLE.
